// File: rtl/bw_pkg.sv
// Shared definitions for the bandwidth arbiter and its requester-side mux.
package bw_pkg;

    localparam int unsigned NCLI = 4;
    localparam int unsigned IDW  = 2;

    typedef enum logic {
        ACCOUNT = 1'b0,
        WINNING = 1'b1
    } bw_phase_e;

    // Returns {valid, idx}; valid only when exactly one bit of g is set.
    function automatic logic [IDW:0] onehot_idx(input logic [NCLI-1:0] g);
        logic [IDW-1:0] idx;
        int unsigned    n;
        idx = '0;
        n   = 0;
        for (int i = 0; i < NCLI; i++) begin
            if (g[i]) begin
                idx = IDW'(i);
                n   = n + 1;
            end
        end
        return {(n == 1), idx};
    endfunction

endpackage

// File: rtl/bw_req_fifo.sv
// Single-client synchronous FIFO with combinational head and occupancy count.
module bw_req_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DW-1:0]              din,
    input  logic                       pop,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bw_req_mux.sv
// Requester side of the 4-way bandwidth arbiter: per-client queues, req generation,
// grant-driven pop onto a shared registered output, served counters and error flags.
module bw_req_mux
    import bw_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCLI-1:0]      in_valid,
    input  logic [NCLI*DW-1:0]   in_data,
    output logic [NCLI-1:0]      in_ready,
    output logic [NCLI-1:0]      req,
    input  logic [NCLI-1:0]      grant,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [IDW-1:0]       out_id,
    output logic [NCLI*CNTW-1:0] served_cnt,
    output logic                 err_multi,
    output logic                 err_empty
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   cnt    [NCLI];
    logic [DW-1:0]   head   [NCLI];
    logic [CNTW-1:0] served [NCLI];
    logic [NCLI-1:0] full;
    logic [NCLI-1:0] push;
    logic [NCLI-1:0] pop;
    logic [IDW:0]    gsel;
    logic            g_one;
    logic [IDW-1:0]  g_idx;
    logic            g_nonempty;
    logic            pop_en;

    for (genvar i = 0; i < NCLI; i++) begin : g_cli
        bw_req_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .din   (in_data[i*DW +: DW]),
            .pop   (pop[i]),
            .dout  (head[i]),
            .count (cnt[i]),
            .full  (full[i])
        );

        assign in_ready[i] = !full[i];
        assign push[i]     = in_valid[i] && !full[i];
        // Drop req as the last entry is granted so the registered arbiter never overshoots.
        assign req[i]      = (cnt[i] >= CW'(2)) || ((cnt[i] == CW'(1)) && !grant[i]);
        assign served_cnt[i*CNTW +: CNTW] = served[i];
    end

    // Grant decode: pop only on a one-hot grant to a non-empty client.
    always_comb begin
        gsel       = onehot_idx(grant);
        g_one      = gsel[IDW];
        g_idx      = gsel[IDW-1:0];
        g_nonempty = (cnt[g_idx] != '0);
        pop_en     = g_one && g_nonempty;
        pop        = '0;
        if (pop_en) pop[g_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            err_multi <= 1'b0;
            err_empty <= 1'b0;
            for (int i = 0; i < NCLI; i++) served[i] <= '0;
        end else begin
            out_valid <= pop_en;
            if (pop_en) begin
                out_data <= head[g_idx];
                out_id   <= g_idx;
                if (served[g_idx] != '1) served[g_idx] <= served[g_idx] + CNTW'(1);
            end
            if ((grant != '0) && !g_one) err_multi <= 1'b1;
            if (g_one && !g_nonempty)    err_empty <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bw_req_mux.sv
// Directed scoreboard bench for bw_req_mux.
module tb_bw_req_mux;
    import bw_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned CNTW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NCLI-1:0]      in_valid;
    logic [NCLI*DW-1:0]   in_data;
    logic [NCLI-1:0]      in_ready;
    logic [NCLI-1:0]      req;
    logic [NCLI-1:0]      grant;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [IDW-1:0]       out_id;
    logic [NCLI*CNTW-1:0] served_cnt;
    logic                 err_multi;
    logic                 err_empty;

    int total = 0;
    int bad   = 0;
    logic [IDW+DW-1:0] exp_q [$];

    bw_req_mux #(.DW(DW), .DEPTH(4), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .req        (req),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .served_cnt (served_cnt),
        .err_multi  (err_multi),
        .err_empty  (err_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int cli, input logic [DW-1:0] v);
        in_valid = '0;
        in_valid[cli] = 1'b1;
        in_data[cli*DW +: DW] = v;
        step();
        in_valid = '0;
    endtask

    task automatic expect_pop(input int cli, input logic [DW-1:0] v);
        exp_q.push_back({IDW'(cli), v});
    endtask

    // Monitor: every out_valid must match the oldest expected entry.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got id=%0d data=%0h want no output", out_id, out_data);
            end else begin
                logic [IDW+DW-1:0] e;
                e = exp_q.pop_front();
                check("out_id", 64'(out_id), 64'(e[IDW+DW-1:DW]));
                check("out_data", 64'(out_data), 64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = '0;
        in_data  = '0;
        grant    = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_req", 64'(req), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'hF);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_id", 64'(out_id), 64'h0);
        check("rst_served", 64'(served_cnt), 64'h0);
        check("rst_errs", 64'({err_multi, err_empty}), 64'h0);

        // Client 2: three entries drained by three consecutive grants.
        push_one(2, 32'h0A);
        push_one(2, 32'h0B);
        push_one(2, 32'h0C);
        #1 check("c2_req", 64'(req), 64'h4);
        grant = 4'b0100;
        expect_pop(2, 32'h0A);
        expect_pop(2, 32'h0B);
        expect_pop(2, 32'h0C);
        for (int i = 0; i < 3; i++) begin
            #1 check("c2_req_during_grant", 64'(req[2]), 64'(i < 2));
            step();
        end
        grant = '0;
        #1 check("c2_served", 64'(served_cnt[2*CNTW +: CNTW]), 64'd3);
        step();
        check("c2_idle_valid", 64'(out_valid), 64'h0);
        check("c2_hold_data", 64'(out_data), 64'h0C);
        check("c2_hold_id", 64'(out_id), 64'd2);
        check("c2_req_empty", 64'(req), 64'h0);

        // Client 0: single entry, req drops in the grant cycle.
        push_one(0, 32'h11);
        #1 check("c0_req_before", 64'(req[0]), 64'h1);
        grant = 4'b0001;
        expect_pop(0, 32'h11);
        #1 check("c0_req_in_grant", 64'(req[0]), 64'h0);
        step();
        grant = '0;
        #1 check("c0_valid", 64'(out_valid), 64'h1);
        check("c0_req_after", 64'(req[0]), 64'h0);
        check("c0_err_empty", 64'(err_empty), 64'h0);

        // Client 1: fill to depth, 5th push during a pop is dropped.
        push_one(1, 32'h21);
        push_one(1, 32'h22);
        push_one(1, 32'h23);
        push_one(1, 32'h24);
        #1 check("c1_full_ready", 64'(in_ready), 64'hD);
        in_valid = 4'b0010;
        in_data[1*DW +: DW] = 32'h25;
        grant = 4'b0010;
        expect_pop(1, 32'h21);
        step();
        in_valid = '0;
        #1 check("c1_ready_after_pop", 64'(in_ready[1]), 64'h1);
        expect_pop(1, 32'h22);
        expect_pop(1, 32'h23);
        expect_pop(1, 32'h24);
        repeat (3) step();
        grant = '0;
        #1 check("c1_req_drained", 64'(req), 64'h0);
        check("c1_served", 64'(served_cnt[1*CNTW +: CNTW]), 64'd4);
        step();

        // Multi-bit grant: no pop, sticky err_multi.
        in_valid = 4'b0011;
        in_data[0 +: DW]  = 32'h31;
        in_data[DW +: DW] = 32'h41;
        step();
        in_valid = '0;
        grant = 4'b0011;
        step();
        grant = '0;
        #1 check("multi_valid", 64'(out_valid), 64'h0);
        check("multi_err", 64'({err_multi, err_empty}), 64'h2);
        step();
        check("multi_sticky", 64'(err_multi), 64'h1);
        check("multi_counts", 64'(req), 64'h3);
        grant = 4'b0001;
        expect_pop(0, 32'h31);
        step();
        grant = 4'b0010;
        expect_pop(1, 32'h41);
        step();
        grant = '0;
        step();

        // Grant to empty client 3.
        grant = 4'b1000;
        step();
        grant = '0;
        #1 check("empty_err", 64'(err_empty), 64'h1);
        check("empty_valid", 64'(out_valid), 64'h0);
        step();

        // Reset with entries queued in clients 0 and 3.
        in_valid = 4'b1001;
        in_data[0 +: DW]    = 32'h51;
        in_data[3*DW +: DW] = 32'h71;
        step();
        in_data[0 +: DW]    = 32'h52;
        in_data[3*DW +: DW] = 32'h72;
        step();
        in_valid = '0;
        #1 check("pre_rst_req", 64'(req), 64'h9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_req", 64'(req), 64'h0);
        check("mid_rst_ready", 64'(in_ready), 64'hF);
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_served", 64'(served_cnt), 64'h0);
        check("mid_rst_errs", 64'({err_multi, err_empty}), 64'h0);
        repeat (3) step();

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
